// File: rtl/alu_scoreboard.sv
// ALU result scoreboard: queues golden results from expected records, checks observed results in order.
// Optional build macro ALU_SB_STOP_ON_FAIL_EN freezes all checking after the first failure.
module alu_scoreboard #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [31:0]              exp_a,
  input  logic [31:0]              exp_b,
  input  logic [3:0]               exp_op,
  input  logic                     obs_valid,
  input  logic [31:0]              obs_result,
  input  logic                     obs_zero,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [CNT_W-1:0]         skip_cnt,
  output logic                     mismatch,
  output logic                     underflow,
  output logic [3:0]               first_op,
  output logic [31:0]              first_exp,
  output logic [31:0]              first_obs,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 38;

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, skip_q, skip_d;
  logic             mismatch_q, mismatch_d, underflow_q, underflow_d;
  logic [3:0]       first_op_q, first_op_d;
  logic [31:0]      first_exp_q, first_exp_d, first_obs_q, first_obs_d;

  logic [31:0] gold;
  logic        gold_skip;
  logic        full, empty, frozen;
  logic        push, pop, udf;
  logic [EW-1:0] head;
  logic [31:0] head_gold;
  logic        head_zero, head_skip, hit;
  logic [3:0]  head_op;
  logic        do_pass, do_fail, do_skip;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    gold      = 32'd0;
    gold_skip = 1'b0;
    case (exp_op)
      4'b0000: gold = exp_a + exp_b;
      4'b0001: gold = exp_a - exp_b;
      4'b0010: gold = exp_a & exp_b;
      4'b0011: gold = exp_a | exp_b;
      4'b0101: gold = {31'd0, ($signed(exp_a) < $signed(exp_b))};
      default: gold_skip = 1'b1;
    endcase
  end

`ifdef ALU_SB_STOP_ON_FAIL_EN
  assign frozen = mismatch_q;
`else
  assign frozen = 1'b0;
`endif

  // exp_ready is derived from registered level only, so a same-cycle pop never opens it early
  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign exp_ready = ~full & ~frozen;

  assign push = exp_valid & exp_ready & ~clear;
  assign pop  = obs_valid & ~empty & ~frozen & ~clear;
  assign udf  = obs_valid &  empty & ~frozen & ~clear;

  assign head      = mem[rd_ptr_q];
  assign head_gold = head[37:6];
  assign head_zero = head[5];
  assign head_op   = head[4:1];
  assign head_skip = head[0];
  assign hit       = (obs_result == head_gold) && (obs_zero == head_zero);

  assign do_pass = pop & ~head_skip &  hit;
  assign do_fail = pop & ~head_skip & ~hit;
  assign do_skip = pop &  head_skip;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    skip_d      = skip_q;
    mismatch_d  = mismatch_q;
    underflow_d = underflow_q;
    first_op_d  = first_op_q;
    first_exp_d = first_exp_q;
    first_obs_d = first_obs_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      pass_d      = '0;
      fail_d      = '0;
      skip_d      = '0;
      mismatch_d  = 1'b0;
      underflow_d = 1'b0;
      first_op_d  = '0;
      first_exp_d = '0;
      first_obs_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (do_pass) pass_d = sat_inc(pass_q);
      if (do_skip) skip_d = sat_inc(skip_q);
      if (udf)     underflow_d = 1'b1;
      if (do_fail) begin
        fail_d     = sat_inc(fail_q);
        mismatch_d = 1'b1;
        if (!mismatch_q) begin
          first_op_d  = head_op;
          first_exp_d = head_gold;
          first_obs_d = obs_result;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {gold, (gold == 32'd0), exp_op, gold_skip};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      skip_q      <= '0;
      mismatch_q  <= 1'b0;
      underflow_q <= 1'b0;
      first_op_q  <= '0;
      first_exp_q <= '0;
      first_obs_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      skip_q      <= skip_d;
      mismatch_q  <= mismatch_d;
      underflow_q <= underflow_d;
      first_op_q  <= first_op_d;
      first_exp_q <= first_exp_d;
      first_obs_q <= first_obs_d;
    end
  end

  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign skip_cnt  = skip_q;
  assign mismatch  = mismatch_q;
  assign underflow = underflow_q;
  assign first_op  = first_op_q;
  assign first_exp = first_exp_q;
  assign first_obs = first_obs_q;
  assign level     = level_q;

endmodule

// File: tb/tb_alu_scoreboard.sv
// Directed-vector bench for alu_scoreboard; expected values are hand-computed per scenario.
module tb_alu_scoreboard;

  logic        clk, rst_n, clear;
  logic        exp_valid, exp_ready;
  logic [31:0] exp_a, exp_b;
  logic [3:0]  exp_op;
  logic        obs_valid, obs_zero;
  logic [31:0] obs_result;
  logic [15:0] pass_cnt, fail_cnt, skip_cnt;
  logic        mismatch, underflow;
  logic [3:0]  first_op;
  logic [31:0] first_exp, first_obs;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;

  alu_scoreboard #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_a(exp_a), .exp_b(exp_b), .exp_op(exp_op),
    .obs_valid(obs_valid), .obs_result(obs_result), .obs_zero(obs_zero),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
    .mismatch(mismatch), .underflow(underflow),
    .first_op(first_op), .first_exp(first_exp), .first_obs(first_obs),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus: inputs applied at a negedge, held across the posedge, released at the next negedge.
  task automatic cyc(input logic ev, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                     input logic ov, input logic [31:0] r, input logic z);
    exp_valid = ev; exp_a = a; exp_b = b; exp_op = op;
    obs_valid = ov; obs_result = r; obs_zero = z;
    @(negedge clk);
    exp_valid = 1'b0; obs_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    cyc(1'b1, a, b, op, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic obs(input logic [31:0] r, input logic z);
    cyc(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, r, z);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (pass_cnt !== 16'd0) begin errors++; $display("FAIL reset_pass got=%0d exp=0", pass_cnt); end
    checks++; if (fail_cnt !== 16'd0) begin errors++; $display("FAIL reset_fail got=%0d exp=0", fail_cnt); end
    checks++; if (skip_cnt !== 16'd0) begin errors++; $display("FAIL reset_skip got=%0d exp=0", skip_cnt); end
    checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", exp_ready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if ({mismatch, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {mismatch, underflow}); end
    checks++; if ({first_op, first_exp, first_obs} !== 68'd0) begin errors++; $display("FAIL reset_capture got=%h exp=0", {first_op, first_exp, first_obs}); end
  endtask

  task automatic test_basic();
    do_clear();
    push(32'd15, 32'd10, 4'b0000);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL basic_level1 got=%0d exp=1", level); end
    obs(32'd25, 1'b0);
    checks++; if (pass_cnt !== 16'd1) begin errors++; $display("FAIL basic_pass got=%0d exp=1", pass_cnt); end
    checks++; if (fail_cnt !== 16'd0) begin errors++; $display("FAIL basic_fail got=%0d exp=0", fail_cnt); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL basic_level0 got=%0d exp=0", level); end
  endtask

  task automatic test_order();
    do_clear();
    push(32'd20, 32'd10, 4'b0001);
    push(32'd12, 32'd7,  4'b0010);
    push(32'd5,  32'd3,  4'b0011);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL order_level got=%0d exp=3", level); end
    obs(32'd10, 1'b0);
    obs(32'd4,  1'b0);
    checks++; if (pass_cnt !== 16'd2) begin errors++; $display("FAIL order_pass got=%0d exp=2", pass_cnt); end
    obs(32'd9, 1'b0);
    checks++; if (fail_cnt !== 16'd1) begin errors++; $display("FAIL order_fail got=%0d exp=1", fail_cnt); end
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL order_mismatch got=%b exp=1", mismatch); end
    checks++; if (first_op !== 4'b0011) begin errors++; $display("FAIL order_first_op got=%b exp=0011", first_op); end
    checks++; if (first_exp !== 32'd7) begin errors++; $display("FAIL order_first_exp got=%0d exp=7", first_exp); end
    checks++; if (first_obs !== 32'd9) begin errors++; $display("FAIL order_first_obs got=%0d exp=9", first_obs); end
  endtask

`ifdef ALU_SB_STOP_ON_FAIL_EN
  task automatic test_stop_on_fail();
    checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL stop_ready got=%b exp=0", exp_ready); end
    push(32'd1, 32'd1, 4'b0000);
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL stop_level got=%0d exp=0", level); end
    obs(32'd2, 1'b0);
    checks++; if ({pass_cnt, fail_cnt, skip_cnt} !== {16'd2, 16'd1, 16'd0}) begin errors++; $display("FAIL stop_counts got=%0d/%0d/%0d exp=2/1/0", pass_cnt, fail_cnt, skip_cnt); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL stop_underflow got=%b exp=0", underflow); end
    do_clear();
    checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL stop_clear_ready got=%b exp=1", exp_ready); end
  endtask
`else
  task automatic test_continue_after_fail();
    push(32'd1, 32'd1, 4'b0000);
    obs(32'd5, 1'b0);
    checks++; if (fail_cnt !== 16'd2) begin errors++; $display("FAIL cont_fail got=%0d exp=2", fail_cnt); end
    checks++; if ({first_op, first_exp, first_obs} !== {4'b0011, 32'd7, 32'd9}) begin errors++; $display("FAIL cont_capture_held got=%h/%0d/%0d exp=3/7/9", first_op, first_exp, first_obs); end
    push(32'd2, 32'd2, 4'b0000);
    obs(32'd4, 1'b0);
    checks++; if (pass_cnt !== 16'd3) begin errors++; $display("FAIL cont_pass got=%0d exp=3", pass_cnt); end
  endtask
`endif

  task automatic test_signed();
    do_clear();
    push(32'hFFFF_FFFF, 32'd1, 4'b0101);
    obs(32'd1, 1'b0);
    checks++; if (pass_cnt !== 16'd1) begin errors++; $display("FAIL slt_neg_pass got=%0d exp=1", pass_cnt); end
    push(32'd5, 32'd3, 4'b0101);
    obs(32'd0, 1'b1);
    checks++; if (pass_cnt !== 16'd2) begin errors++; $display("FAIL slt_false_pass got=%0d exp=2", pass_cnt); end
    push(32'd5, 32'd5, 4'b0001);
    obs(32'd0, 1'b0);
    checks++; if (fail_cnt !== 16'd1) begin errors++; $display("FAIL zero_flag_fail got=%0d exp=1", fail_cnt); end
    checks++; if ({first_op, first_exp, first_obs} !== {4'b0001, 32'd0, 32'd0}) begin errors++; $display("FAIL zero_flag_capture got=%h/%0d/%0d exp=1/0/0", first_op, first_exp, first_obs); end
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < 4; i++) push(32'(i), 32'(i), 4'b0000);
    checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", exp_ready); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level got=%0d exp=4", level); end
    push(32'd100, 32'd100, 4'b0000);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_drop_level got=%0d exp=4", level); end
    // push offered while full and popping in the same cycle must be dropped
    cyc(1'b1, 32'd50, 32'd50, 4'b0000, 1'b1, 32'd0, 1'b1);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_pop_level got=%0d exp=3", level); end
    checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got=%b exp=1", exp_ready); end
    obs(32'd2, 1'b0);
    obs(32'd4, 1'b0);
    obs(32'd6, 1'b0);
    checks++; if (pass_cnt !== 16'd4) begin errors++; $display("FAIL full_pass got=%0d exp=4", pass_cnt); end
    checks++; if ({fail_cnt, level, underflow} !== {16'd0, 3'd0, 1'b0}) begin errors++; $display("FAIL full_drain got=%0d/%0d/%b exp=0/0/0", fail_cnt, level, underflow); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    push(32'd1, 32'd2, 4'b0000);
    cyc(1'b1, 32'd3, 32'd4, 4'b0000, 1'b1, 32'd3, 1'b0);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level got=%0d exp=1", level); end
    obs(32'd7, 1'b0);
    checks++; if (pass_cnt !== 16'd2) begin errors++; $display("FAIL b2b_pass got=%0d exp=2", pass_cnt); end
    do_clear();
    cyc(1'b1, 32'd2, 32'd3, 4'b0000, 1'b1, 32'd5, 1'b0);
    checks++; if ({underflow, level, pass_cnt} !== {1'b1, 3'd1, 16'd0}) begin errors++; $display("FAIL empty_push_obs got=%b/%0d/%0d exp=1/1/0", underflow, level, pass_cnt); end
    obs(32'd5, 1'b0);
    checks++; if (pass_cnt !== 16'd1) begin errors++; $display("FAIL empty_push_later got=%0d exp=1", pass_cnt); end
  endtask

  task automatic test_skip_underflow();
    do_clear();
    obs(32'd77, 1'b0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_flag got=%b exp=1", underflow); end
    checks++; if ({pass_cnt, fail_cnt, skip_cnt} !== 48'd0) begin errors++; $display("FAIL udf_counts got=%0d/%0d/%0d exp=0/0/0", pass_cnt, fail_cnt, skip_cnt); end
    push(32'd1, 32'd1, 4'b1111);
    obs(32'd123, 1'b0);
    checks++; if ({pass_cnt, fail_cnt, skip_cnt} !== {16'd0, 16'd0, 16'd1}) begin errors++; $display("FAIL skip_counts got=%0d/%0d/%0d exp=0/0/1", pass_cnt, fail_cnt, skip_cnt); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL skip_mismatch got=%b exp=0", mismatch); end
    push(32'd9, 32'd9, 4'b0000);
    push(32'd1, 32'd1, 4'b0000);
    // clear wins over a simultaneous push and pop
    clear = 1'b1;
    cyc(1'b1, 32'd1, 32'd1, 4'b0000, 1'b1, 32'd99, 1'b0);
    clear = 1'b0;
    checks++; if ({skip_cnt, fail_cnt, level} !== {16'd0, 16'd0, 3'd0}) begin errors++; $display("FAIL clear_state got=%0d/%0d/%0d exp=0/0/0", skip_cnt, fail_cnt, level); end
    checks++; if ({underflow, mismatch, exp_ready} !== 3'b001) begin errors++; $display("FAIL clear_flags got=%b exp=001", {underflow, mismatch, exp_ready}); end
  endtask

  task automatic test_async_reset();
    do_clear();
    push(32'd1, 32'd1, 4'b0000);
    push(32'd2, 32'd2, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({level, exp_ready} !== {3'd0, 1'b1}) begin errors++; $display("FAIL async_rst got=%0d/%b exp=0/1", level, exp_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    obs(32'd2, 1'b0);
    checks++; if ({underflow, pass_cnt} !== {1'b1, 16'd0}) begin errors++; $display("FAIL async_rst_lost got=%b/%0d exp=1/0", underflow, pass_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0;
    exp_valid = 1'b0; exp_a = '0; exp_b = '0; exp_op = '0;
    obs_valid = 1'b0; obs_result = '0; obs_zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_order();
`ifdef ALU_SB_STOP_ON_FAIL_EN
    test_stop_on_fail();
`else
    test_continue_after_fail();
`endif
    test_signed();
    test_full();
    test_back_to_back();
    test_skip_underflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
